axi_crossbar_wr_route: RTL

- Write-data router for one crossbar slave port.
- Sits directly downstream of the slave port's address decode/admission stage and consumes its write command: select, decode-error flag, valid/ready.
- For a decoded write, steers W beats from the slave port to the selected master port until wlast.
- For a decode-error write, sinks the W burst, counts its beats, then tells the B-response path that the DECERR burst's data has been fully drained.

---
 rtl/axi_crossbar_wr_route.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_crossbar_wr_route.sv
// Write-data router for one crossbar slave port.
// Steers W bursts to the selected master port, or drains and counts DECERR bursts.
module axi_crossbar_wr_route #(
    parameter int M_COUNT      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int WUSER_ENABLE = 0,
    parameter int WUSER_WIDTH  = 1,
    localparam int SEL_WIDTH   = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SEL_WIDTH-1:0]           s_wc_select,
    input  logic                           s_wc_decerr,
    input  logic                           s_wc_valid,
    output logic                           s_wc_ready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]          s_axi_wstrb,
    input  logic                           s_axi_wlast,
    input  logic [WUSER_WIDTH-1:0]         s_axi_wuser,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [M_COUNT*DATA_WIDTH-1:0]  m_axi_wdata,
    output logic [M_COUNT*STRB_WIDTH-1:0]  m_axi_wstrb,
    output logic [M_COUNT-1:0]             m_axi_wlast,
    output logic [M_COUNT*WUSER_WIDTH-1:0] m_axi_wuser,
    output logic [M_COUNT-1:0]             m_axi_wvalid,
    input  logic [M_COUNT-1:0]             m_axi_wready,
    output logic                           m_decerr_done_valid,
    output logic [8:0]                     m_decerr_done_beats,
    input  logic                           m_decerr_done_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DRAIN,
        DONE
    } state_t;

    state_t               state;
    logic [SEL_WIDTH-1:0] sel_reg;
    logic [8:0]           cnt;
    logic [8:0]           cnt_sat;
    logic                 done_valid;

    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [STRB_WIDTH-1:0]  out_strb;
    logic                   out_last;
    logic [WUSER_WIDTH-1:0] out_user;
    logic [SEL_WIDTH-1:0]   out_sel;

    logic                   skid_valid;
    logic [DATA_WIDTH-1:0]  skid_data;
    logic [STRB_WIDTH-1:0]  skid_strb;
    logic                   skid_last;
    logic [WUSER_WIDTH-1:0] skid_user;
    logic [SEL_WIDTH-1:0]   skid_sel;
    logic                   skid_ready_reg;

    logic in_fire;
    logic drain_fire;
    logic out_ready;
    logic out_valid_next;
    logic skid_valid_next;
    logic skid_ready_next;
    logic load_out_in;
    logic load_out_skid;
    logic load_skid;

    always_comb begin
        s_wc_ready   = 1'b0;
        s_axi_wready = 1'b0;
        unique case (state)
            IDLE:  s_wc_ready   = 1'b1;
            ROUTE: s_axi_wready = skid_ready_reg;
            DRAIN: s_axi_wready = 1'b1;
            DONE:  s_axi_wready = 1'b0;
        endcase
    end

    assign in_fire    = (state == ROUTE) && s_axi_wvalid && s_axi_wready;
    assign drain_fire = (state == DRAIN) && s_axi_wvalid;
    assign cnt_sat    = (cnt == 9'd256) ? cnt : cnt + 9'd1;

    assign m_decerr_done_valid = done_valid;
    assign m_decerr_done_beats = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_reg    <= '0;
            cnt        <= '0;
            done_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_wc_valid) begin
                        sel_reg <= s_wc_select;
                        state   <= s_wc_decerr ? DRAIN : ROUTE;
                    end
                end
                ROUTE: begin
                    if (in_fire && s_axi_wlast)
                        state <= IDLE;
                end
                DRAIN: begin
                    if (drain_fire) begin
                        cnt <= cnt_sat;
                        if (s_axi_wlast) begin
                            state      <= DONE;
                            done_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (m_decerr_done_ready) begin
                        state      <= IDLE;
                        done_valid <= 1'b0;
                        cnt        <= '0;
                    end
                end
            endcase
        end
    end

    assign out_ready = out_valid && m_axi_wready[out_sel];

    // Ready is registered, so a beat arriving while the output stalls lands in the skid.
    always_comb begin
        out_valid_next  = out_valid;
        skid_valid_next = skid_valid;
        load_out_in     = 1'b0;
        load_out_skid   = 1'b0;
        load_skid       = 1'b0;
        if (skid_ready_reg) begin
            if (out_ready || !out_valid) begin
                out_valid_next = in_fire;
                load_out_in    = in_fire;
            end else begin
                skid_valid_next = in_fire;
                load_skid       = in_fire;
            end
        end else if (out_ready) begin
            out_valid_next  = skid_valid;
            skid_valid_next = 1'b0;
            load_out_skid   = 1'b1;
        end
        skid_ready_next = out_ready ||
                          (!skid_valid && (!out_valid || !in_fire));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            skid_valid     <= 1'b0;
            skid_ready_reg <= 1'b1;
        end else begin
            out_valid      <= out_valid_next;
            skid_valid     <= skid_valid_next;
            skid_ready_reg <= skid_ready_next;
        end
    end

    always_ff @(posedge clk) begin
        if (load_out_in) begin
            out_data <= s_axi_wdata;
            out_strb <= s_axi_wstrb;
            out_last <= s_axi_wlast;
            out_user <= s_axi_wuser;
            out_sel  <= sel_reg;
        end else if (load_out_skid) begin
            out_data <= skid_data;
            out_strb <= skid_strb;
            out_last <= skid_last;
            out_user <= skid_user;
            out_sel  <= skid_sel;
        end
        if (load_skid) begin
            skid_data <= s_axi_wdata;
            skid_strb <= s_axi_wstrb;
            skid_last <= s_axi_wlast;
            skid_user <= s_axi_wuser;
            skid_sel  <= sel_reg;
        end
    end

    always_comb begin
        m_axi_wvalid = '0;
        for (int i = 0; i < M_COUNT; i++)
            m_axi_wvalid[i] = out_valid && (out_sel == SEL_WIDTH'(i));
    end

    assign m_axi_wdata = {M_COUNT{out_data}};
    assign m_axi_wstrb = {M_COUNT{out_strb}};
    assign m_axi_wlast = {M_COUNT{out_last}};

    generate
        if (WUSER_ENABLE != 0) begin : g_user
            assign m_axi_wuser = {M_COUNT{out_user}};
        end else begin : g_nouser
            assign m_axi_wuser = '0;
        end
    endgenerate

endmodule
